msb_rd_sequencer: RTL



---
 rtl/msb_rd_sequencer.sv | 99 +++++++++
 1 files changed

// File: rtl/msb_rd_sequencer.sv
// msb_rd_sequencer: expands burst requests into one (stream, line, offset) read address per 16B beat.
// Ports: clk/reset (sync, active-high); i_v/i_r handshake a burst request carrying
// i_st (stream), i_cl (start line), i_of (start beat offset), i_len (beats minus one);
// o_v/o_r handshake each beat address o_st/o_cl/o_of, tagged with o_first/o_last.
module msb_rd_sequencer #(
  parameter int STREAMS = 16,
  parameter int LINES   = 16,
  parameter int WAYS    = 8,
  parameter int LEN_W   = 4,
  parameter int ST_W    = $clog2(STREAMS),
  parameter int CL_W    = $clog2(LINES),
  parameter int OF_W    = $clog2(WAYS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_v,
  output logic            i_r,
  input  logic [ST_W-1:0] i_st,
  input  logic [CL_W-1:0] i_cl,
  input  logic [OF_W-1:0] i_of,
  input  logic [LEN_W-1:0] i_len,
  output logic            o_v,
  input  logic            o_r,
  output logic [ST_W-1:0] o_st,
  output logic [CL_W-1:0] o_cl,
  output logic [OF_W-1:0] o_of,
  output logic            o_first,
  output logic            o_last
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t r_state, w_state;
  logic [ST_W-1:0]  r_st, w_st;
  logic [CL_W-1:0]  r_cl, w_cl;
  logic [OF_W-1:0]  r_of, w_of;
  logic [LEN_W-1:0] r_rem, w_rem;
  logic r_first, w_first, r_last, w_last;
  logic w_beat, w_req, w_wrap;
  assign o_v     = r_state == BURST;
  assign o_st    = r_st;
  assign o_cl    = r_cl;
  assign o_of    = r_of;
  assign o_first = r_first;
  assign o_last  = r_last;
  assign w_beat  = o_v & o_r;
  // ready again during the final beat so the next burst follows with no bubble
  assign i_r     = (r_state == IDLE) | (w_beat & r_last);
  assign w_req   = i_v & i_r;
  assign w_wrap  = r_of == OF_W'(WAYS - 1);
  always_comb begin
    w_state = r_state;
    w_st    = r_st;
    w_cl    = r_cl;
    w_of    = r_of;
    w_rem   = r_rem;
    w_first = r_first;
    w_last  = r_last;
    if (w_req) begin
      w_state = BURST;
      w_st    = i_st;
      w_cl    = i_cl;
      w_of    = i_of;
      w_rem   = i_len;
      w_first = 1'b1;
      w_last  = i_len == '0;
    end else if (w_beat && r_last) begin
      w_state = IDLE;
      w_first = 1'b0;
      w_last  = 1'b0;
    end else if (w_beat) begin
      w_first = 1'b0;
      w_rem   = r_rem - LEN_W'(1);
      w_last  = r_rem == LEN_W'(1);
      // line and offset widths are powers of two, so both wrap for free
      w_of    = w_wrap ? '0 : r_of + OF_W'(1);
      w_cl    = r_cl + CL_W'(w_wrap);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_st    <= '0;
      r_cl    <= '0;
      r_of    <= '0;
      r_rem   <= '0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_st    <= w_st;
      r_cl    <= w_cl;
      r_of    <= w_of;
      r_rem   <= w_rem;
      r_first <= w_first;
      r_last  <= w_last;
    end
  end
  a_stable: assert property (@(posedge clk) disable iff (reset)
    (o_v && !o_r) |=> (o_v && $stable({o_st, o_cl, o_of, o_first, o_last})));
endmodule
